// File: rtl/shift_tx_ctrl.sv
// Serial frame transmitter controller: parallel-loads a shift register and
// frames its serial output as idle-high start / N data LSB-first / stop.
module shift_tx_ctrl #(
    parameter int N   = 8,
    parameter int DIV = 4
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic [N-1:0] data,
    input  logic         valid,
    output logic         ready,
    output logic         sr_load,
    output logic         sr_en,
    output logic [N-1:0] sr_par,
    input  logic         sr_sout,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  hold_q, hold_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;

    logic bit_end;
    logic last_bit;
    logic accept;
    logic timed;

    assign bit_end  = (div_cnt_q == DIV_LAST);
    assign last_bit = (bit_cnt_q == BIT_LAST);
    assign accept   = (state_q == IDLE) && valid;
    assign timed    = (state_q == START) || (state_q == DATA) ||
                      (state_q == STOP);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (valid) state_d = LOAD;
            LOAD:    state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && last_bit) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready   = (state_q == IDLE);
        busy    = (state_q != IDLE);
        tx      = 1'b1;
        sr_load = 1'b0;
        sr_en   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: ;
            LOAD: begin
                sr_load = 1'b1;
                sr_en   = 1'b1;
            end
            START: tx = 1'b0;
            DATA: begin
                tx    = sr_sout;
                sr_en = bit_end;
            end
            STOP:    done = bit_end;
            default: ;
        endcase
    end

    assign sr_par = hold_q;

    // Bit timer wraps at every bit end and restarts on any state change
    always_comb begin
        hold_d    = accept ? data : hold_q;
        div_cnt_d = '0;
        bit_cnt_d = '0;
        if (timed && (state_d == state_q) && !bit_end) begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
        if (state_q == DATA) begin
            bit_cnt_d = bit_cnt_q;
            if (bit_end) begin
                bit_cnt_d = last_bit ? '0 : bit_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            hold_q    <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            hold_q    <= hold_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule
